match_window_monitor: RTL and testbench

//  Downstream consumer of the 1001 sequence detector's Moore output. Rising-edge

---
 rtl/match_window_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_match_window_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_window_monitor.sv
// -----------------------------------------------------------------------------
// match_window_monitor
//
// Consumes the Moore output of the 1001 sequence detector. Each rising edge of
// det is one match. Matches are counted over back-to-back programmable windows
// and into a saturating lifetime total. A sticky alarm is raised when a
// completed window's count reaches the threshold.
//
// Optional feature: define MATCH_GAP_EN to build the inter-match gap counter.
// Without it, gap_out and gap_valid are tied to 0 but the ports remain.
//
// Parameters
//   WIN_W  width of win_len and the window down-counter
//   CNT_W  width of per-window count, total and threshold
//   GAP_W  width of the inter-match gap counter
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous, active-high reset
//   det          detector match output (high one or more cycles per match)
//   enable       1 = run windows, 0 = idle / abort the current window
//   win_len      window length in cycles, sampled at each window start
//   thresh       alarm threshold, 0 disables the alarm
//   clr          synchronous clear of total, alarm and gap history
//   match_pulse  1-cycle pulse, one clk after each det rising edge
//   win_count    match count of the last completed window
//   win_done     1-cycle pulse in the cycle win_count takes its new value
//   total        lifetime match count, saturating at all-ones
//   alarm        sticky, set when a window count >= thresh (thresh != 0)
//   gap_out      cycles between the last two matches
//   gap_valid    1-cycle pulse in the cycle gap_out takes its new value
// -----------------------------------------------------------------------------
module match_window_monitor #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8,
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clr,
    output logic             match_pulse,
    output logic [CNT_W-1:0] win_count,
    output logic             win_done,
    output logic [CNT_W-1:0] total,
    output logic             alarm,
    output logic [GAP_W-1:0] gap_out,
    output logic             gap_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             det_d;
    logic             det_rise;
    logic [WIN_W-1:0] wcnt, wcnt_nxt;
    logic [WIN_W-1:0] win_len_eff;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] acc_start;
    logic [CNT_W-1:0] win_count_nxt;
    logic             win_done_nxt;
    logic             alarm_set;

    // A det held high for several cycles is a single match.
    assign det_rise = det & ~det_d;

    // A zero-length window would never terminate; treat it as one cycle.
    assign win_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign acc_inc     = (acc == CNT_MAX) ? acc : acc + CNT_W'(1);
    // An edge in the cycle a window is (re)started is the first of that window.
    assign acc_start   = det_rise ? CNT_W'(1) : '0;

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        acc_nxt       = acc;
        win_count_nxt = win_count;
        win_done_nxt  = 1'b0;
        alarm_set     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_COUNT;
                    wcnt_nxt  = win_len_eff;
                    acc_nxt   = acc_start;
                end
            end
            S_COUNT: begin
                if (!enable) begin
                    // Abort: the partial window is dropped without a report.
                    state_nxt = S_IDLE;
                end else begin
                    if (det_rise) begin
                        acc_nxt = acc_inc;
                    end
                    // wcnt holds the number of COUNT cycles left, this one included.
                    if (wcnt == WIN_W'(1)) begin
                        state_nxt = S_REPORT;
                    end else begin
                        wcnt_nxt = wcnt - WIN_W'(1);
                    end
                end
            end
            S_REPORT: begin
                win_count_nxt = acc;
                win_done_nxt  = 1'b1;
                alarm_set     = (thresh != '0) && (acc >= thresh);
                if (enable) begin
                    state_nxt = S_COUNT;
                    wcnt_nxt  = win_len_eff;
                    acc_nxt   = acc_start;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            det_d       <= 1'b0;
            wcnt        <= '0;
            acc         <= '0;
            match_pulse <= 1'b0;
            win_count   <= '0;
            win_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            det_d       <= det;
            wcnt        <= wcnt_nxt;
            acc         <= acc_nxt;
            match_pulse <= det_rise;
            win_count   <= win_count_nxt;
            win_done    <= win_done_nxt;
        end
    end

    // Lifetime total counts regardless of enable; clr wins over a same-cycle edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total <= '0;
        end else if (clr) begin
            total <= '0;
        end else if (det_rise && (total != CNT_MAX)) begin
            total <= total + CNT_W'(1);
        end
    end

    // A new alarm condition wins over a same-cycle clr so it is never missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (alarm_set) begin
            alarm <= 1'b1;
        end else if (clr) begin
            alarm <= 1'b0;
        end
    end

`ifdef MATCH_GAP_EN
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_armed;

    // gap_cnt holds the cycles elapsed since the previous edge; the first edge
    // after rst/clr has no predecessor, so it only arms the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt   <= '0;
            gap_armed <= 1'b0;
            gap_out   <= '0;
            gap_valid <= 1'b0;
        end else begin
            gap_valid <= 1'b0;
            if (clr) begin
                gap_cnt   <= '0;
                gap_armed <= 1'b0;
            end else if (det_rise) begin
                if (gap_armed) begin
                    gap_out   <= gap_cnt;
                    gap_valid <= 1'b1;
                end
                gap_armed <= 1'b1;
                gap_cnt   <= GAP_W'(1);
            end else if (gap_armed && (gap_cnt != GAP_MAX)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end
`else
    assign gap_out   = '0;
    assign gap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_match_window_monitor.sv
// -----------------------------------------------------------------------------
// tb_match_window_monitor
//
// Directed bench for match_window_monitor. Expected window counts are queued
// when a window's stimulus is written and compared whenever win_done pulses.
// -----------------------------------------------------------------------------
module tb_match_window_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       det;
    logic       enable;
    logic [7:0] win_len;
    logic [7:0] thresh;
    logic       clr;
    logic       match_pulse;
    logic [7:0] win_count;
    logic       win_done;
    logic [7:0] total;
    logic       alarm;
    logic [15:0] gap_out;
    logic       gap_valid;

    int checks = 0;
    int errors = 0;
    int mp_cnt = 0;
    int wd_cnt = 0;
    int gv_cnt = 0;
    int gap_bad = 0;
    int exp_q[$];
    int mp0;
    int wd0;
    int gv0;

    match_window_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .det         (det),
        .enable      (enable),
        .win_len     (win_len),
        .thresh      (thresh),
        .clr         (clr),
        .match_pulse (match_pulse),
        .win_count   (win_count),
        .win_done    (win_done),
        .total       (total),
        .alarm       (alarm),
        .gap_out     (gap_out),
        .gap_valid   (gap_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; win_done pops the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (match_pulse === 1'b1) mp_cnt++;
        if (gap_valid === 1'b1) gv_cnt++;
`ifndef MATCH_GAP_EN
        if (gap_valid !== 1'b0 || gap_out !== 16'd0) gap_bad++;
`endif
        if (win_done === 1'b1) begin
            wd_cnt++;
            if (exp_q.size() == 0) check("win_done_unexpected", {31'd0, win_done}, 32'd0);
            else check("win_count", {24'd0, win_count}, exp_q.pop_front());
        end
    endtask

    task automatic cyc(input logic d);
        det = d;
        tick();
    endtask

    initial begin
        rst = 1'b0; det = 1'b0; enable = 1'b0; clr = 1'b0;
        win_len = 8'd0; thresh = 8'd0;
        #1 rst = 1'b1;
        #1;
        check("rst_match_pulse", {31'd0, match_pulse}, 32'd0);
        check("rst_win_count", {24'd0, win_count}, 32'd0);
        check("rst_win_done", {31'd0, win_done}, 32'd0);
        check("rst_total", {24'd0, total}, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Window of 8, edges in COUNT cycles 2 and 5, threshold met exactly.
        enable = 1'b1; win_len = 8'd8; thresh = 8'd2;
        exp_q.push_back(2);
        wd0 = wd_cnt;
        cyc(1'b0);
        cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
        check("t1_no_early_done", wd_cnt, wd0);
        enable = 1'b0;
        cyc(1'b0);
        check("t1_done_after_8", wd_cnt, wd0 + 1);
        check("t1_alarm", {31'd0, alarm}, 32'd1);
        tick();
        check("t1_done_one_cycle", {31'd0, win_done}, 32'd0);
        check("t1_total", {24'd0, total}, 32'd2);

        // det held high for three cycles is one match.
        enable = 1'b1; win_len = 8'd6; thresh = 8'd0;
        exp_q.push_back(1);
        cyc(1'b0);
        mp0 = mp_cnt;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check("t2_one_pulse", mp_cnt, mp0 + 1);
        check("t2_total", {24'd0, total}, 32'd3);
        check("t2_alarm_sticky", {31'd0, alarm}, 32'd1);

        // clr clears total and alarm, win_count holds.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_total", {24'd0, total}, 32'd0);
        check("clr_alarm", {31'd0, alarm}, 32'd0);
        check("clr_win_count_held", {24'd0, win_count}, 32'd1);

        // thresh = 0: five matches never raise the alarm.
        enable = 1'b1; win_len = 8'd12; thresh = 8'd0;
        exp_q.push_back(5);
        cyc(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1); cyc(1'b0);
        end
        cyc(1'b0); cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check("t3_alarm_off", {31'd0, alarm}, 32'd0);
        check("t3_total", {24'd0, total}, 32'd5);

        // Back-to-back windows: last-cycle edge, edge in REPORT, win_len change mid-window.
        enable = 1'b1; win_len = 8'd4; thresh = 8'd3;
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
        wd0 = wd_cnt;
        cyc(1'b0);
        cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1);
        cyc(1'b0);
        check("bb_a_done", wd_cnt, wd0 + 1);
        cyc(1'b0);
        win_len = 8'd2;
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        check("bb_b_len_unchanged", wd_cnt, wd0 + 1);
        cyc(1'b1);
        check("bb_b_done", wd_cnt, wd0 + 2);
        cyc(1'b1); cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check("bb_c_done", wd_cnt, wd0 + 3);
        check("bb_alarm", {31'd0, alarm}, 32'd0);
        check("bb_total", {24'd0, total}, 32'd8);

        // Saturation, clr beating an edge, alarm set beating clr.
        mp0 = mp_cnt;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1); cyc(1'b0);
        end
        check("sat_total", {24'd0, total}, 32'd255);
        check("sat_pulses", mp_cnt, mp0 + 300);
        clr = 1'b1;
        cyc(1'b1);
        clr = 1'b0;
        check("clr_beats_edge", {24'd0, total}, 32'd0);
        check("clr_edge_pulse", {31'd0, match_pulse}, 32'd1);
        cyc(1'b0);
        enable = 1'b1; win_len = 8'd2; thresh = 8'd1;
        exp_q.push_back(1);
        cyc(1'b0);
        cyc(1'b1); cyc(1'b0);
        clr = 1'b1; enable = 1'b0;
        cyc(1'b0);
        clr = 1'b0;
        check("set_beats_clr", {31'd0, alarm}, 32'd1);
        check("set_clr_total", {24'd0, total}, 32'd0);

        // Abort in COUNT cycle 4: no report, win_count unchanged, next window fresh.
        enable = 1'b1; win_len = 8'd8;
        wd0 = wd_cnt;
        cyc(1'b0);
        cyc(1'b1); cyc(1'b0); cyc(1'b1);
        enable = 1'b0;
        cyc(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_done", wd_cnt, wd0);
        check("abort_win_count", {24'd0, win_count}, 32'd1);
        enable = 1'b1; win_len = 8'd3;
        exp_q.push_back(1);
        cyc(1'b0);
        cyc(1'b0); cyc(1'b1); cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        check("restart_done", wd_cnt, wd0 + 1);

        // Asynchronous reset in the middle of a window.
        enable = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        check("pre_rst_pulse", {31'd0, match_pulse}, 32'd1);
        check("pre_rst_total", {24'd0, total}, 32'd4);
        #1 rst = 1'b1;
        #1;
        check("async_match_pulse", {31'd0, match_pulse}, 32'd0);
        check("async_win_count", {24'd0, win_count}, 32'd0);
        check("async_total", {24'd0, total}, 32'd0);
        check("async_alarm", {31'd0, alarm}, 32'd0);
        check("async_win_done", {31'd0, win_done}, 32'd0);
        check("async_gap_out", {16'd0, gap_out}, 32'd0);
        enable = 1'b0; det = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef MATCH_GAP_EN
        // First edge only arms; second edge four cycles later reports 4.
        gv0 = gv_cnt;
        cyc(1'b1);
        check("gap_first_arms", {31'd0, gap_valid}, 32'd0);
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        cyc(1'b1);
        check("gap_valid", {31'd0, gap_valid}, 32'd1);
        check("gap_out", {16'd0, gap_out}, 32'd4);
        cyc(1'b0);
        check("gap_valid_one_cycle", {31'd0, gap_valid}, 32'd0);
        check("gap_count", gv_cnt, gv0 + 1);
`endif

        // win_len = 0 behaves as a one-cycle window.
        enable = 1'b1; win_len = 8'd0; thresh = 8'd0;
        exp_q.push_back(1);
        wd0 = wd_cnt;
        cyc(1'b0);
        cyc(1'b1);
        enable = 1'b0;
        cyc(1'b0);
        check("len0_done", wd_cnt, wd0 + 1);
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
`ifndef MATCH_GAP_EN
        check("gap_tied_off", gap_bad, 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
